regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/def.svh | 3 +
 rtl/regfile.sv | 50 +++++
 tb/tb_regfile.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/def.svh
`ifndef DATA_WIDTH
`define DATA_WIDTH 4
`endif

// File: rtl/regfile.sv
// regfile: A/B/OUT/PC registers with carry flag and ALU operand mux.
// Optional halt input enabled by defining REGFILE_HALT_EN.
`include "def.svh"
module regfile (
  input  logic                   clk,
  input  logic                   n_reset,
`ifdef REGFILE_HALT_EN
  input  logic                   halt,
`endif
  input  logic [1:0]             sel,
  input  logic [3:0]             load,
  input  logic                   jnc,
  input  logic [`DATA_WIDTH-1:0] in_port,
  input  logic [`DATA_WIDTH-1:0] alu_out,
  input  logic                   alu_c,
  output logic [`DATA_WIDTH-1:0] ain,
  output logic [`DATA_WIDTH-1:0] a_q,
  output logic [`DATA_WIDTH-1:0] b_q,
  output logic [`DATA_WIDTH-1:0] out_port,
  output logic [`DATA_WIDTH-1:0] pc,
  output logic                   c_flag
);
  logic run;
  logic pc_load;
`ifdef REGFILE_HALT_EN
  assign run = !halt;
`else
  assign run = 1'b1;
`endif
  // jnc looks at the carry flag held before this edge
  assign pc_load = load[3] && (!jnc || !c_flag);
  always_comb
    ain = sel == 2'b00 ? a_q :
          sel == 2'b01 ? b_q :
          sel == 2'b10 ? in_port : '0;
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      a_q      <= '0;
      b_q      <= '0;
      out_port <= '0;
      pc       <= '0;
      c_flag   <= 1'b0;
    end else if (run) begin
      if (load[0]) a_q <= alu_out;
      if (load[1]) b_q <= alu_out;
      if (load[2]) out_port <= alu_out;
      pc <= pc_load ? alu_out : pc + 1'b1;
      if (|load) c_flag <= alu_c;
    end
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed stimulus, reference model and per-cycle compare for regfile.
module tb_regfile;
  localparam int W = 4;
  localparam int M = 1 << W;
  logic clk = 1'b0;
  logic n_reset;
  logic [1:0] sel;
  logic [3:0] load;
  logic jnc;
  logic [W-1:0] in_port, alu_out, ain, a_q, b_q, out_port, pc;
  logic alu_c, c_flag;
  logic halt;
  int checks = 0;
  int errors = 0;
  bit comparing = 1'b0;
  int ma, mb, mo, mp, mc;
  int snap_a, snap_b, snap_o, snap_p, snap_c, p0;

  always #5 clk = ~clk;

  regfile dut (
    .clk(clk),
    .n_reset(n_reset),
`ifdef REGFILE_HALT_EN
    .halt(halt),
`endif
    .sel(sel),
    .load(load),
    .jnc(jnc),
    .in_port(in_port),
    .alu_out(alu_out),
    .alu_c(alu_c),
    .ain(ain),
    .a_q(a_q),
    .b_q(b_q),
    .out_port(out_port),
    .pc(pc),
    .c_flag(c_flag)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_ain();
    return sel == 2'd0 ? ma : sel == 2'd1 ? mb : sel == 2'd2 ? int'(in_port) : 0;
  endfunction

  always @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      ma <= 0; mb <= 0; mo <= 0; mp <= 0; mc <= 0;
    end else if (!halt) begin
      if (load[0]) ma <= alu_out;
      if (load[1]) mb <= alu_out;
      if (load[2]) mo <= alu_out;
      mp <= (load[3] && !(jnc && mc == 1)) ? int'(alu_out) : (mp + 1) % M;
      if (load != 4'd0) mc <= alu_c;
    end

  always @(negedge clk)
    if (comparing) begin
      chk("ain", ain, model_ain());
      chk("a_q", a_q, ma);
      chk("b_q", b_q, mb);
      chk("out_port", out_port, mo);
      chk("pc", pc, mp);
      chk("c_flag", c_flag, mc);
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_a"}, a_q, 0);
    chk({tag, "_b"}, b_q, 0);
    chk({tag, "_out"}, out_port, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_c"}, c_flag, 0);
  endtask

  initial begin
    n_reset = 1'b0; halt = 1'b0; sel = 2'd0; load = 4'd0; jnc = 1'b0;
    in_port = '0; alu_out = '0; alu_c = 1'b0;
    step();
    step();
    all_zero("reset");
    n_reset = 1'b1;
    comparing = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("idle_pc", pc, (i + 1) % 16);
      chk("idle_a", a_q, 0);
    end
    sel = 2'd2; in_port = 4'b0101; alu_out = 4'b0101; load = 4'b0001;
    #1 chk("ain_in_port", ain, 5);
    step();
    load = 4'd0; sel = 2'd0;
    #1 chk("ain_a", ain, 5);
    chk("a_load", a_q, 5);
    alu_out = 4'b1010; alu_c = 1'b1; load = 4'b0110;
    step();
    load = 4'd0;
    chk("b_load", b_q, 10);
    chk("out_load", out_port, 10);
    chk("c_set", c_flag, 1);
    chk("a_hold", a_q, 5);
    sel = 2'd1;
    #1 chk("ain_b", ain, 10);
    sel = 2'd3;
    #1 chk("ain_zero", ain, 0);
    p0 = pc;
    load = 4'b1000; jnc = 1'b1; alu_out = 4'b0011; alu_c = 1'b0;
    step();
    chk("jnc_suppressed", pc, (p0 + 1) % 16);
    chk("c_cleared", c_flag, 0);
    step();
    chk("jnc_taken", pc, 3);
    jnc = 1'b0; alu_out = 4'b1111;
    step();
    chk("jump_15", pc, 15);
    load = 4'd0;
    step();
    chk("pc_wrap", pc, 0);
    load = 4'b0111; alu_out = 4'b1001; alu_c = 1'b1; sel = 2'd0;
    step();
    chk("multi_a", a_q, 9);
    chk("multi_c", c_flag, 1);
    load = 4'b1111; alu_out = 4'b0110;
    #3 n_reset = 1'b0;
    #1 all_zero("async_rst");
    step();
    all_zero("rst_hold");
    load = 4'd0;
    n_reset = 1'b1;
    step();
    chk("resume_pc", pc, 1);
    chk("resume_a", a_q, 0);
`ifdef REGFILE_HALT_EN
    load = 4'b0001; alu_out = 4'd7;
    step();
    snap_a = a_q; snap_b = b_q; snap_o = out_port; snap_p = pc; snap_c = c_flag;
    halt = 1'b1; load = 4'b1111; alu_out = 4'd12; alu_c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_a", a_q, snap_a);
      chk("halt_b", b_q, snap_b);
      chk("halt_out", out_port, snap_o);
      chk("halt_pc", pc, snap_p);
      chk("halt_c", c_flag, snap_c);
    end
    halt = 1'b0; load = 4'd0;
    step();
    chk("halt_resume", pc, (snap_p + 1) % 16);
`endif
    @(negedge clk);
    #1 comparing = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
